// File: rtl/life_generation_engine.sv
// rtl/life_generation_engine.sv - Game-of-Life generation engine, one cell per cycle.
// Neighbours come from the committed board; the next board is built beside it and swapped in COMMIT.
module life_generation_engine #(
  parameter int          X       = 8,
  parameter int          Y       = 8,
  parameter int          LOG2X   = 3,
  parameter int          LOG2Y   = 3,
  parameter logic [8:0]  BIRTH   = 9'b000001000,
  parameter logic [8:0]  SURVIVE = 9'b000001100,
  parameter int          GENW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [X*Y-1:0]           load_data,
  input  logic                     start,
  input  logic [GENW-1:0]          num_gens,
  input  logic                     wrap,
  output logic                     busy,
  output logic                     done,
  output logic [X*Y-1:0]           board,
  output logic [LOG2X+LOG2Y-1:0]   cell_idx,
  output logic [GENW-1:0]          gen_count,
  output logic [LOG2X+LOG2Y:0]     population
);

  localparam int N  = X * Y;
  localparam int IW = LOG2X + LOG2Y;
  localparam int PW = IW + 1;
  localparam logic [15:0] BIRTH_EXT   = 16'(BIRTH);
  localparam logic [15:0] SURVIVE_EXT = 16'(SURVIVE);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     board_r, next_r;
  logic [PW-1:0]    acc, pop_r;
  logic [GENW-1:0]  remaining, gen_r;
  logic [IW-1:0]    idx_r;
  logic             wrap_r, done_r;

  logic [LOG2X-1:0] cx, xm, xp;
  logic [LOG2Y-1:0] cy, ym, yp;
  logic             xm_ok, xp_ok, ym_ok, yp_ok;
  logic [3:0]       nbr;
  logic             alive, new_cell;

  assign cx = idx_r[LOG2X-1:0];
  assign cy = idx_r[IW-1:LOG2X];
  // Power-of-two board: plain modular arithmetic gives toroidal wrap for free.
  assign xm = cx - LOG2X'(1);
  assign xp = cx + LOG2X'(1);
  assign ym = cy - LOG2Y'(1);
  assign yp = cy + LOG2Y'(1);
  assign xm_ok = wrap_r || (cx != '0);
  assign xp_ok = wrap_r || (cx != LOG2X'(X - 1));
  assign ym_ok = wrap_r || (cy != '0);
  assign yp_ok = wrap_r || (cy != LOG2Y'(Y - 1));

  always_comb begin
    nbr = 4'd0;
    nbr = nbr + {3'b0, ym_ok & xm_ok & board_r[{ym, xm}]};
    nbr = nbr + {3'b0, ym_ok &         board_r[{ym, cx}]};
    nbr = nbr + {3'b0, ym_ok & xp_ok & board_r[{ym, xp}]};
    nbr = nbr + {3'b0,         xm_ok & board_r[{cy, xm}]};
    nbr = nbr + {3'b0,         xp_ok & board_r[{cy, xp}]};
    nbr = nbr + {3'b0, yp_ok & xm_ok & board_r[{yp, xm}]};
    nbr = nbr + {3'b0, yp_ok &         board_r[{yp, cx}]};
    nbr = nbr + {3'b0, yp_ok & xp_ok & board_r[{yp, xp}]};
  end

  assign alive    = board_r[idx_r];
  assign new_cell = alive ? SURVIVE_EXT[nbr] : BIRTH_EXT[nbr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!load && start && num_gens != '0) state_nxt = SCAN;
      SCAN:    if (idx_r == IW'(N - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = (remaining == GENW'(1)) ? IDLE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_r   <= '0;
      next_r    <= '0;
      acc       <= '0;
      pop_r     <= '0;
      remaining <= '0;
      gen_r     <= '0;
      idx_r     <= '0;
      wrap_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            board_r <= load_data;
            gen_r   <= '0;
            pop_r   <= '0;
          end else if (start) begin
            if (num_gens == '0) begin
              done_r <= 1'b1;
            end else begin
              remaining <= num_gens;
              wrap_r    <= wrap;
              idx_r     <= '0;
              acc       <= '0;
            end
          end
        end
        SCAN: begin
          next_r[idx_r] <= new_cell;
          acc           <= acc + PW'(new_cell);
          idx_r         <= idx_r + IW'(1);
        end
        COMMIT: begin
          board_r   <= next_r;
          pop_r     <= acc;
          acc       <= '0;
          gen_r     <= gen_r + GENW'(1);
          remaining <= remaining - GENW'(1);
          idx_r     <= '0;
          if (remaining == GENW'(1)) done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = done_r;
  assign board      = board_r;
  assign cell_idx   = idx_r;
  assign gen_count  = gen_r;
  assign population = pop_r;

endmodule

// File: tb/tb_life_generation_engine.sv
// tb/tb_life_generation_engine.sv - Self-checking bench: table vectors, random boards vs array model.
module tb_life_generation_engine;
  localparam int X = 8, Y = 8, N = 64, GPER = N + 1;
  localparam logic [8:0] B3 = 9'b000001000, S23 = 9'b000001100, B36 = 9'b001001000;

  logic clk = 0, rst = 1, load = 0, start = 0, wrap = 0;
  logic [N-1:0] load_data = '0;
  logic [15:0] num_gens = '0;
  logic busy, done, busy_hl, done_hl;
  logic [N-1:0] board, board_hl;
  logic [5:0] cell_idx, cell_idx_hl;
  logic [15:0] gen_count, gen_count_hl;
  logic [6:0] population, population_hl;

  int tests = 0, fails = 0;
  logic [N-1:0] rb, rb_hl;
  int rgen;

  always #5 clk = ~clk;

  life_generation_engine dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .start(start),
    .num_gens(num_gens), .wrap(wrap), .busy(busy), .done(done), .board(board),
    .cell_idx(cell_idx), .gen_count(gen_count), .population(population));

  life_generation_engine #(.BIRTH(B36)) dut_hl (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .start(start),
    .num_gens(num_gens), .wrap(wrap), .busy(busy_hl), .done(done_hl), .board(board_hl),
    .cell_idx(cell_idx_hl), .gen_count(gen_count_hl), .population(population_hl));

  // Reference: count neighbours on a 2-D grid and apply the rule masks directly.
  function automatic logic [N-1:0] life_step(input logic [N-1:0] b, input logic w,
                                             input logic [8:0] br, input logic [8:0] sv);
    logic [N-1:0] r;
    r = '0;
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            if (dx == 0 && dy == 0) continue;
            nx = x + dx; ny = y + dy;
            if (w) begin nx = (nx + X) % X; ny = (ny + Y) % Y; end
            else if (nx < 0 || nx >= X || ny < 0 || ny >= Y) continue;
            n += int'(b[ny*X + nx]);
          end
        r[y*X + x] = b[y*X + x] ? sv[n] : br[n];
      end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [N-1:0] ld);
    @(negedge clk);
    load = 1; load_data = ld;
    @(negedge clk);
    load = 0;
    rb = ld; rb_hl = ld; rgen = 0;
  endtask

  // Starts a run and returns at the negedge of the done cycle (or when the bound expires).
  task automatic do_start(input logic w, input int ng, output int lat, output int busy_cnt);
    start = 1; wrap = w; num_gens = 16'(ng);
    @(negedge clk);
    start = 0;
    lat = 1; busy_cnt = 0;
    while (done !== 1'b1 && lat < ng * GPER + 10) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk("done_hl", done_hl, 1);
    for (int g = 0; g < ng; g++) begin
      rb = life_step(rb, w, B3, S23);
      rb_hl = life_step(rb_hl, w, B36, S23);
    end
    rgen += ng;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_board"}, board, rb);
    chk({tag, "_pop"}, population, $countones(rb));
    chk({tag, "_gen"}, gen_count, 16'(rgen));
    chk({tag, "_board_hl"}, board_hl, rb_hl);
    chk({tag, "_pop_hl"}, population_hl, $countones(rb_hl));
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] ld;
    logic         w;
    int           ng;
    logic [N-1:0] exp_board;
    int           exp_pop;
  } vec_t;

  function automatic logic [N-1:0] bits(input int a, input int b, input int c, input int d);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  initial begin
    vec_t vt[4];
    int lat, bc;
    logic [N-1:0] keep, hl_seed;

    vt[0] = '{"blinker",   bits(19,27,35,-1), 1'b0, 1, bits(26,27,28,-1), 3};
    vt[1] = '{"torus",     bits(24,25,31,-1), 1'b1, 1, bits(16,24,32,-1), 3};
    vt[2] = '{"edge_dead", bits(24,25,31,-1), 1'b0, 1, '0, 0};
    vt[3] = '{"block",     bits(0,1,8,9),     1'b0, 5, bits(0,1,8,9), 4};

    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_board", board, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_pop", population, 0);
    chk("rst_idx", cell_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    foreach (vt[i]) begin
      do_load(vt[i].ld);
      do_start(vt[i].w, vt[i].ng, lat, bc);
      chk({vt[i].name, "_lat"}, lat, 1 + vt[i].ng * GPER);
      chk({vt[i].name, "_busy_cycles"}, bc, vt[i].ng * GPER);
      chk({vt[i].name, "_board_tbl"}, board, vt[i].exp_board);
      chk({vt[i].name, "_pop_tbl"}, population, vt[i].exp_pop);
      chk({vt[i].name, "_gen_tbl"}, gen_count, vt[i].ng);
      check_model(vt[i].name);
      @(negedge clk);
      chk({vt[i].name, "_done_pulse"}, done, 0);
    end

    for (int r = 0; r < 6; r++) begin
      logic w;
      int ng;
      w = 1'($urandom);
      ng = $urandom_range(1, 3);
      do_load({$urandom, $urandom});
      do_start(w, ng, lat, bc);
      chk("rand_lat", lat, 1 + ng * GPER);
      check_model("rand");
    end

    keep = board;
    do_start(1'b0, 0, lat, bc);
    chk("zero_lat", lat, 1);
    chk("zero_busy", bc, 0);
    chk("zero_busy_now", busy, 0);
    check_model("zero");

    @(negedge clk);
    load = 1; start = 1; num_gens = 3; load_data = 64'h0123_4567_89ab_cdef;
    @(negedge clk);
    load = 0; start = 0;
    rb = load_data; rb_hl = load_data; rgen = 0;
    chk("ldst_busy", busy, 0);
    chk("ldst_board", board, 64'h0123_4567_89ab_cdef);
    chk("ldst_gen", gen_count, 0);
    @(negedge clk);
    chk("ldst_busy2", busy, 0);
    chk("ldst_done", done, 0);

    do_load(bits(19,27,35,-1));
    do_start(1'b0, 1, lat, bc);
    do_start(1'b0, 1, lat, bc);
    chk("restart_lat", lat, 1 + GPER);
    chk("restart_board", board, bits(19,27,35,-1));
    check_model("restart");

    do_load(bits(19,27,35,-1));
    start = 1; wrap = 0; num_gens = 1;
    @(negedge clk);
    start = 0;
    chk("scan_idx0", cell_idx, 0);
    chk("scan_busy", busy, 1);
    repeat (9) @(negedge clk);
    chk("scan_idx9", cell_idx, 9);
    load = 1; load_data = '1; start = 1; wrap = 1; num_gens = 7;
    @(negedge clk);
    load = 0; start = 0;
    lat = 11;
    while (done !== 1'b1 && lat < 80) begin @(negedge clk); lat++; end
    chk("prot_lat", lat, 66);
    rb = life_step(rb, 1'b0, B3, S23);
    rb_hl = life_step(rb_hl, 1'b0, B36, S23);
    rgen = 1;
    check_model("prot");

    start = 1; wrap = 0; num_gens = 2;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_board", board, 0);
    chk("mid_rst_gen", gen_count, 0);
    chk("mid_rst_idx", cell_idx, 0);
    rb = '0; rb_hl = '0; rgen = 0;
    check_model("mid_rst");

    hl_seed = bits(18,19,20,26) | bits(28,36,-1,-1);
    do_load(hl_seed);
    do_start(1'b0, 1, lat, bc);
    chk("hl_born27", board_hl[27], 1);
    chk("b3_not_born27", board[27], 0);
    check_model("hl");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/life_generation_engine.md
Name: life_generation_engine

Overview:
Self-sequenced Game-of-Life generation engine for an X-by-Y board held in an internal register.
- On start, scans every cell once per generation and counts its eight neighbours, with edges either dead or toroidal.
- Applies a parameterised birth/survive rule, then commits the new board.
- Repeats for a requested number of generations and reports generation count and population.
- Successor to the fixed 8x8 dead-edge neighbour extractor: adds wrap mode, rule masks, sequencing and a start/done handshake.

Parameters:
X, 8, board width in cells; must equal 2**LOG2X, minimum 4
Y, 8, board height in cells; must equal 2**LOG2Y, minimum 4
LOG2X, 3, log2 of X
LOG2Y, 3, log2 of Y
BIRTH, 9'b000001000, bit n=1: dead cell with n live neighbours is born (default B3)
SURVIVE, 9'b000001100, bit n=1: live cell with n live neighbours survives (default S23)
GENW, 16, width of generation counters

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  load board from load_data (honoured only in IDLE)
load_data  input  X*Y  board image; cell (x,y) at bit y*X+x, 1=alive
start  input  1  begin run (honoured only in IDLE, when load=0)
num_gens  input  GENW  generations to compute in this run
wrap  input  1  0=out-of-board neighbours dead, 1=toroidal
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run
board  output  X*Y  committed board, same bit order as load_data
cell_idx  output  LOG2X+LOG2Y  cell currently being scanned: y in upper bits, x in lower bits
gen_count  output  GENW  generations committed since last load/reset; wraps modulo 2**GENW
population  output  LOG2X+LOG2Y+1  live cells in last committed generation

Behaviour:
- Reset (synchronous, active-high): state=IDLE; board, gen_count, population, cell_idx = 0; busy=0, done=0. Takes effect mid-run; the partial next-board is discarded.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE
  - load=1: board<=load_data, gen_count<=0, population<=0. load beats start in the same cycle, and start is then ignored.
  - start=1 with num_gens=0: no state change; done=1 next cycle.
  - start=1 with num_gens>0: latch remaining=num_gens and wrap_r=wrap; cell_idx<=0; go to SCAN.
- SCAN (one cell per cycle)
  - Neighbour count n (0..8, 4 bits) for cell (x,y) is taken from the committed board, never the partial next-board.
  - wrap_r=0: any neighbour with x-1<0, x+1>X-1, y-1<0 or y+1>Y-1 counts as dead.
  - wrap_r=1: coordinates wrap modulo X and Y.
  - next[idx] = alive ? SURVIVE[n] : BIRTH[n].
  - The population accumulator adds next[idx].
  - cell_idx increments; after idx=X*Y-1, go to COMMIT.
- COMMIT (1 cycle)
  - board<=next; population<=accumulator; accumulator cleared; gen_count<=gen_count+1 (modulo); remaining decrements.
  - remaining was 1: go to IDLE.
  - Otherwise: cell_idx<=0, go to SCAN.
- busy=1 in SCAN and COMMIT. load and start are ignored while busy, and wrap changes mid-run have no effect.
- Timing: start sampled in cycle t; first SCAN in cycle t+1; each generation takes X*Y+1 cycles.
  - done=1 for exactly one cycle at t+1+N*(X*Y+1), the first IDLE cycle.
  - board, gen_count and population are final in that same cycle.
- start asserted in the done cycle with load=0 begins a new run.

Test Plan:
- Blinker, wrap=0, 8x8: load bits 19,27,35; start num_gens=1 at t -> done only at t+66; board bits 26,27,28 only; population=3; gen_count=1.
- Toroidal edge, wrap=1: load bits 24,25,31; num_gens=1 -> board bits 16,24,32 only; population=3. Same load with wrap=0 -> board=0, population=0.
- Block still life: load bits 0,1,8,9; num_gens=5 -> done at t+326; board unchanged; gen_count=5; population=4; busy high t+1..t+325.
- num_gens=0 -> done at t+1, busy never high, board and gen_count unchanged. Simultaneous load+start in IDLE -> board loaded, no run.
- Busy protection / reset: load and start pulses during SCAN ignored and board unaffected. rst asserted at t+20 -> from t+21 busy=0, done=0, board=0, gen_count=0, cell_idx=0.
- Rule override BIRTH=9'b001001000 (HighLife B36): dead cell at index 27 with neighbours at indices 18,19,20,26,28,36 -> cell 27 born after one generation (not born with default BIRTH).
